// File: rtl/video_pkg.sv
// Shared constants and helpers for the pointer sprite source.
// Register map addresses and the 2bpp pixel-field selector.
package video_pkg;

    localparam int unsigned PTR_SHAPE_BASE = 0;
    localparam int unsigned PTR_PAL_BASE   = 128;
    localparam int unsigned PTR_CTRL       = 131;

    localparam logic [1:0] PTR_CODE_TRANSPARENT = 2'd0;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_t;

    // Leftmost pixel lives in the MSBs of the shape word.
    function automatic logic [1:0] ptr_pix_code(
        input logic [15:0] word,
        input logic [2:0]  idx
    );
        logic [15:0] shifted;
        shifted = word << {idx, 1'b0};
        return shifted[15:14];
    endfunction

endpackage

// File: rtl/video_pointer_ram.sv
// 128x16 shape RAM: port A read/write for the CPU, port B read for pixels.
// Both ports read the array before any same-edge write lands.
module video_pointer_ram (
    input  logic        clk,
    input  logic        a_en,
    input  logic        a_we,
    input  logic [6:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic [15:0] a_rdata,
    input  logic [6:0]  b_addr,
    output logic [15:0] b_rdata
);

    logic [15:0] mem_q [128];
    logic [15:0] a_rdata_q;
    logic [15:0] b_rdata_q;

    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) begin
                mem_q[a_addr] <= a_wdata;
            end
            a_rdata_q <= mem_q[a_addr];
        end
        b_rdata_q <= mem_q[b_addr];
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/video_pointer_sprite.sv
// Pointer sprite source: 32x32 2bpp shape, 3-entry palette, CPU reg port.
// Pixel fetch has a fixed one-cycle latency from request to colour.
module video_pointer_sprite
    import video_pkg::*;
#(
    parameter int COLOR_BITS = 4,
    parameter int ADDR_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            pointer_x,
    input  logic [4:0]            pointer_y,
    input  logic                  pointer_active,
    output logic [COLOR_BITS-1:0] pointer_r,
    output logic [COLOR_BITS-1:0] pointer_g,
    output logic [COLOR_BITS-1:0] pointer_b,
    output logic                  pointer_opaque,
    input  logic                  bus_req,
    input  logic                  bus_we,
    input  logic [ADDR_BITS-1:0]  bus_addr,
    input  logic [15:0]           bus_wdata,
    output logic [15:0]           bus_rdata,
    output logic                  bus_ack
);

    localparam int PW = 3 * COLOR_BITS;

    bus_state_t state_q, state_d;
    logic [PW-1:0] pal_q [3];
    logic [PW-1:0] pal_d [3];
    logic          enable_q, enable_d;
    logic [15:0]   reg_rdata_q, reg_rdata_d;
    logic          is_shape_q, is_shape_d;
    logic [2:0]    idx_q, idx_d;
    logic          active_q, active_d;

    logic          accept;
    logic          is_shape;
    logic [15:0]   ram_rdata_a;
    logic [15:0]   ram_rdata_b;
    logic [1:0]    code;
    logic [PW-1:0] rgb;

    assign accept   = (state_q == BUS_IDLE) && bus_req;
    assign is_shape = bus_addr < ADDR_BITS'(PTR_PAL_BASE);

    video_pointer_ram u_ram (
        .clk     (clk),
        .a_en    (accept && is_shape),
        .a_we    (bus_we),
        .a_addr  (bus_addr[6:0]),
        .a_wdata (bus_wdata),
        .a_rdata (ram_rdata_a),
        .b_addr  ({pointer_y, pointer_x[4:3]}),
        .b_rdata (ram_rdata_b)
    );

    always_comb begin
        state_d     = state_q;
        pal_d       = pal_q;
        enable_d    = enable_q;
        reg_rdata_d = reg_rdata_q;
        is_shape_d  = is_shape_q;
        if (accept) begin
            state_d     = BUS_ACK;
            is_shape_d  = is_shape;
            reg_rdata_d = '0;
            unique case (bus_addr)
                ADDR_BITS'(PTR_PAL_BASE): begin
                    reg_rdata_d = 16'(pal_q[0]);
                    if (bus_we) pal_d[0] = bus_wdata[PW-1:0];
                end
                ADDR_BITS'(PTR_PAL_BASE + 1): begin
                    reg_rdata_d = 16'(pal_q[1]);
                    if (bus_we) pal_d[1] = bus_wdata[PW-1:0];
                end
                ADDR_BITS'(PTR_PAL_BASE + 2): begin
                    reg_rdata_d = 16'(pal_q[2]);
                    if (bus_we) pal_d[2] = bus_wdata[PW-1:0];
                end
                ADDR_BITS'(PTR_CTRL): begin
                    reg_rdata_d = {15'd0, enable_q};
                    if (bus_we) enable_d = bus_wdata[0];
                end
                default: ;
            endcase
        end else if (state_q == BUS_ACK) begin
            state_d = BUS_IDLE;
        end
    end

    assign idx_d    = pointer_x[2:0];
    assign active_d = pointer_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BUS_IDLE;
            pal_q       <= '{default: '0};
            enable_q    <= 1'b0;
            reg_rdata_q <= '0;
            is_shape_q  <= 1'b0;
            idx_q       <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pal_q       <= pal_d;
            enable_q    <= enable_d;
            reg_rdata_q <= reg_rdata_d;
            is_shape_q  <= is_shape_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
        end
    end

    assign bus_ack   = (state_q == BUS_ACK);
    assign bus_rdata = !bus_ack  ? '0
                     : is_shape_q ? ram_rdata_a
                     : reg_rdata_q;

    assign code           = ptr_pix_code(ram_rdata_b, idx_q);
    assign pointer_opaque = active_q && enable_q
                         && (code != PTR_CODE_TRANSPARENT);

    always_comb begin
        rgb = '0;
        if (pointer_opaque) begin
            unique case (code)
                2'd1:    rgb = pal_q[0];
                2'd2:    rgb = pal_q[1];
                2'd3:    rgb = pal_q[2];
                default: rgb = '0;
            endcase
        end
    end

    assign pointer_r = rgb[PW-1 -: COLOR_BITS];
    assign pointer_g = rgb[2*COLOR_BITS-1 -: COLOR_BITS];
    assign pointer_b = rgb[COLOR_BITS-1:0];

endmodule

// File: tb/tb_video_pointer_sprite.sv
// Directed bench for video_pointer_sprite: bus handshake, pixel decode,
// gating, port collision and address/coordinate edge cases.
module tb_video_pointer_sprite;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pointer_x;
    logic [4:0]  pointer_y;
    logic        pointer_active;
    logic [3:0]  pointer_r;
    logic [3:0]  pointer_g;
    logic [3:0]  pointer_b;
    logic        pointer_opaque;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_pointer_sprite dut (
        .clk            (clk),
        .reset          (reset),
        .pointer_x      (pointer_x),
        .pointer_y      (pointer_y),
        .pointer_active (pointer_active),
        .pointer_r      (pointer_r),
        .pointer_g      (pointer_g),
        .pointer_b      (pointer_b),
        .pointer_opaque (pointer_opaque),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack)
    );

    // One transaction; ack/rdata sampled just after the accept edge.
    task automatic bus_xfer(input logic we, input logic [7:0] a,
                            input logic [15:0] d,
                            output logic ack, output logic [15:0] rd);
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        ack = bus_ack;
        rd  = bus_rdata;
        @(negedge clk);
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic pix(input logic [4:0] x, input logic [4:0] y,
                       input logic act);
        @(negedge clk);
        pointer_x = x; pointer_y = y; pointer_active = act;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        logic ack; logic [15:0] rd;
        bus_xfer(1'b1, 8'd131, 16'h0001, ack, rd);
        pix(5'd0, 5'd0, 1'b1);
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 8'd128; bus_wdata = 16'h0FFF;
        #2 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus_ack !== 1'b0 || bus_rdata !== 16'h0 || pointer_opaque !== 1'b0
                || {pointer_r, pointer_g, pointer_b} !== 12'h0) begin
                errors++;
                $display("FAIL reset_outputs: ack=%b rdata=%h opq=%b rgb=%h want all 0",
                         bus_ack, bus_rdata, pointer_opaque,
                         {pointer_r, pointer_g, pointer_b});
            end
        end
        @(negedge clk);
        bus_req = 1'b0; bus_we = 1'b0; reset = 1'b0;
        bus_xfer(1'b0, 8'd131, 16'h0, ack, rd);
        checks++;
        if (ack !== 1'b1 || rd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_enable: ack=%b rdata=%h want ack=1 rdata=0000", ack, rd);
        end
        bus_xfer(1'b0, 8'd128, 16'h0, ack, rd);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_palette: rdata=%h want 0000", rd);
        end
    endtask

    task automatic test_handshake;
        logic ack; logic [15:0] rd;
        logic [5:0] seen;
        bus_xfer(1'b1, 8'd128, 16'h0ABC, ack, rd);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL hs_write_ack: ack=%b want 1", ack);
        end
        bus_xfer(1'b0, 8'd128, 16'h0, ack, rd);
        checks++;
        if (ack !== 1'b1 || rd !== 16'h0ABC) begin
            errors++;
            $display("FAIL hs_read: ack=%b rdata=%h want ack=1 rdata=0abc", ack, rd);
        end
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 8'd128;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen[5-i] = bus_ack;
        end
        @(negedge clk);
        bus_req = 1'b0;
        checks++;
        if (seen !== 6'b101010) begin
            errors++;
            $display("FAIL hs_held_req: ack pattern=%b want 101010", seen);
        end
    endtask

    task automatic test_pixel_decode;
        logic ack; logic [15:0] rd;
        bus_xfer(1'b1, 8'd0,   16'h4000, ack, rd);
        bus_xfer(1'b1, 8'd1,   16'hB000, ack, rd);
        bus_xfer(1'b1, 8'd128, 16'h0F00, ack, rd);
        bus_xfer(1'b1, 8'd129, 16'h00A5, ack, rd);
        bus_xfer(1'b1, 8'd130, 16'h0123, ack, rd);
        bus_xfer(1'b1, 8'd131, 16'h0001, ack, rd);
        pix(5'd0, 5'd0, 1'b1);
        checks++;
        if (pointer_opaque !== 1'b1 || {pointer_r, pointer_g, pointer_b} !== 12'hF00) begin
            errors++;
            $display("FAIL pix_code1: opq=%b rgb=%h want 1 f00", pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
        pix(5'd1, 5'd0, 1'b1);
        checks++;
        if (pointer_opaque !== 1'b0 || {pointer_r, pointer_g, pointer_b} !== 12'h000) begin
            errors++;
            $display("FAIL pix_transparent: opq=%b rgb=%h want 0 000", pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
        pix(5'd8, 5'd0, 1'b1);
        checks++;
        if (pointer_opaque !== 1'b1 || {pointer_r, pointer_g, pointer_b} !== 12'h0A5) begin
            errors++;
            $display("FAIL pix_code2: opq=%b rgb=%h want 1 0a5", pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
        pix(5'd9, 5'd0, 1'b1);
        checks++;
        if (pointer_opaque !== 1'b1 || {pointer_r, pointer_g, pointer_b} !== 12'h123) begin
            errors++;
            $display("FAIL pix_code3: opq=%b rgb=%h want 1 123", pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
    endtask

    task automatic test_gating;
        logic ack; logic [15:0] rd;
        bus_xfer(1'b1, 8'd131, 16'h0000, ack, rd);
        pix(5'd0, 5'd0, 1'b1);
        checks++;
        if (pointer_opaque !== 1'b0 || {pointer_r, pointer_g, pointer_b} !== 12'h000) begin
            errors++;
            $display("FAIL gate_enable: opq=%b rgb=%h want 0 000", pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
        bus_xfer(1'b1, 8'd131, 16'h0001, ack, rd);
        pix(5'd0, 5'd0, 1'b0);
        checks++;
        if (pointer_opaque !== 1'b0 || {pointer_r, pointer_g, pointer_b} !== 12'h000) begin
            errors++;
            $display("FAIL gate_active: opq=%b rgb=%h want 0 000", pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
        pix(5'd0, 5'd0, 1'b1);
        checks++;
        if (pointer_opaque !== 1'b1 || {pointer_r, pointer_g, pointer_b} !== 12'hF00) begin
            errors++;
            $display("FAIL gate_reenable: opq=%b rgb=%h want 1 f00", pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
    endtask

    task automatic test_collision;
        logic ack; logic [15:0] rd;
        bus_xfer(1'b1, 8'd5, 16'h4000, ack, rd);
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 8'd5; bus_wdata = 16'h0000;
        pointer_x = 5'd8; pointer_y = 5'd1; pointer_active = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pointer_opaque !== 1'b1 || {pointer_r, pointer_g, pointer_b} !== 12'hF00) begin
            errors++;
            $display("FAIL collision_old: opq=%b rgb=%h want 1 f00", pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
        @(negedge clk);
        bus_req = 1'b0; bus_we = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pointer_opaque !== 1'b0 || {pointer_r, pointer_g, pointer_b} !== 12'h000) begin
            errors++;
            $display("FAIL collision_new: opq=%b rgb=%h want 0 000", pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
    endtask

    task automatic test_unmapped_wrap;
        logic ack; logic [15:0] rd;
        bus_xfer(1'b1, 8'd200, 16'hFFFF, ack, rd);
        bus_xfer(1'b0, 8'd200, 16'h0, ack, rd);
        checks++;
        if (ack !== 1'b1 || rd !== 16'h0000) begin
            errors++;
            $display("FAIL unmapped_read: ack=%b rdata=%h want ack=1 rdata=0000", ack, rd);
        end
        bus_xfer(1'b1, 8'd131, 16'hFFFF, ack, rd);
        bus_xfer(1'b0, 8'd131, 16'h0, ack, rd);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("FAIL ctrl_mask: rdata=%h want 0001", rd);
        end
        bus_xfer(1'b1, 8'd129, 16'hFFA5, ack, rd);
        bus_xfer(1'b0, 8'd129, 16'h0, ack, rd);
        checks++;
        if (rd !== 16'h0FA5) begin
            errors++;
            $display("FAIL pal_mask: rdata=%h want 0fa5", rd);
        end
        bus_xfer(1'b1, 8'd127, 16'h0003, ack, rd);
        bus_xfer(1'b0, 8'd127, 16'h0, ack, rd);
        checks++;
        if (rd !== 16'h0003) begin
            errors++;
            $display("FAIL shape_read: rdata=%h want 0003", rd);
        end
        pix(5'd31, 5'd31, 1'b1);
        checks++;
        if (pointer_opaque !== 1'b1 || {pointer_r, pointer_g, pointer_b} !== 12'h123) begin
            errors++;
            $display("FAIL corner_pixel: opq=%b rgb=%h want 1 123", pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
        pix(5'd30, 5'd31, 1'b1);
        checks++;
        if (pointer_opaque !== 1'b0) begin
            errors++;
            $display("FAIL corner_neighbour: opq=%b want 0", pointer_opaque);
        end
    endtask

    initial begin
        reset = 1'b1;
        pointer_x = '0; pointer_y = '0; pointer_active = 1'b0;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_ack !== 1'b0 || bus_rdata !== 16'h0 || pointer_opaque !== 1'b0
            || {pointer_r, pointer_g, pointer_b} !== 12'h0) begin
            errors++;
            $display("FAIL por_outputs: ack=%b rdata=%h opq=%b rgb=%h want all 0",
                     bus_ack, bus_rdata, pointer_opaque,
                     {pointer_r, pointer_g, pointer_b});
        end
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_handshake();
        test_pixel_decode();
        test_gating();
        test_collision();
        test_unmapped_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
